// File: rtl/crc4_pkg.sv
// Shared definitions for the CRC4 serial link: generator constants, FSM encoding
// and the single-bit remainder update used by both transmitter and receiver.
package crc4_pkg;

    localparam int unsigned CRC4_W = 4;
    localparam logic [CRC4_W-1:0] CRC4_POLY = 4'b0011;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StData = 2'b01,
        StCrc  = 2'b10,
        StDone = 2'b11
    } crc4_state_e;

    // One step of the MSB-first division by x^4 + POLY.
    function automatic logic [CRC4_W-1:0] crc4_step(
        input logic [CRC4_W-1:0] rem,
        input logic              din,
        input logic [CRC4_W-1:0] poly = CRC4_POLY
    );
        logic fb;
        fb = rem[CRC4_W-1] ^ din;
        return {rem[CRC4_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc4_bit_timer.sv
// Bit-period down-counter: tick pulses on the last clock of every BIT_DIV-clock period.
module crc4_bit_timer #(
    parameter int unsigned BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [3:0] Load = 4'(BIT_DIV - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == 4'd0)) begin
            cnt_d = Load;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    assign tick = (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/crc4_gen_tx.sv
// Serial CRC4 transmitter: shifts a payload word out MSB first, then its 4-bit
// CRC remainder, each bit held for BIT_DIV clocks.
module crc4_gen_tx
    import crc4_pkg::*;
#(
    parameter int unsigned       DATA_W  = 14,
    parameter int unsigned       BIT_DIV = 4,
    parameter logic [CRC4_W-1:0] POLY    = CRC4_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              crc_phase,
    output logic              done
);

    localparam int unsigned CntW = $clog2((DATA_W > CRC4_W) ? DATA_W : CRC4_W);

    crc4_state_e       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CRC4_W-1:0] rem_q, rem_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              ready_q, ready_d;
    logic              dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              crc_phase_q, crc_phase_d;
    logic              done_q, done_d;
    logic              tick;
    logic              timer_clear;

    // Hold the timer at its load value outside a frame so the first bit is full length.
    assign timer_clear = (state_q == StIdle) || (state_q == StDone);

    crc4_bit_timer #(
        .BIT_DIV(BIT_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d   = data_in;
                    rem_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    rem_d   = crc4_step(rem_q, shreg_q[DATA_W-1], POLY);
                    shreg_d = shreg_q << 1;
                    if (bit_cnt_q == CntW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StCrc;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StCrc: begin
                if (tick) begin
                    rem_d = {rem_q[CRC4_W-2:0], 1'b0};
                    if (bit_cnt_q == CntW'(CRC4_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StDone;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        ready_d      = (state_d == StIdle);
        dout_valid_d = (state_d == StData) || (state_d == StCrc);
        crc_phase_d  = (state_d == StCrc);
        done_d       = (state_d == StDone);
        dout_d       = (state_d == StData) ? shreg_d[DATA_W-1] :
                       (state_d == StCrc)  ? rem_d[CRC4_W-1]   : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            rem_q        <= '0;
            bit_cnt_q    <= '0;
            ready_q      <= 1'b1;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            crc_phase_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            rem_q        <= rem_d;
            bit_cnt_q    <= bit_cnt_d;
            ready_q      <= ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            crc_phase_q  <= crc_phase_d;
            done_q       <= done_d;
        end
    end

    assign ready      = ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign crc_phase  = crc_phase_q;
    assign done       = done_q;

endmodule

// File: tb/tb_crc4_gen_tx.sv
// Self-checking bench for crc4_gen_tx: table vectors, random back-to-back frames,
// held-start, mid-frame reset and a BIT_DIV=1 build, against a long-division model.
module tb_crc4_gen_tx;

    localparam int DW = 14;
    localparam int BD = 4;
    localparam int FL = DW + 4;
    localparam int NV = FL * BD;
    localparam int HN = 302;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic          ready, dout, dout_valid, crc_phase, done;
    logic          start1;
    logic [DW-1:0] data1;
    logic          ready1, dout1, dv1, crc1, done1;

    always #5 clk = ~clk;

    crc4_gen_tx #(.DATA_W(DW), .BIT_DIV(BD)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ready(ready),
        .dout(dout), .dout_valid(dout_valid), .crc_phase(crc_phase), .done(done)
    );

    crc4_gen_tx #(.DATA_W(DW), .BIT_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1), .ready(ready1),
        .dout(dout1), .dout_valid(dv1), .crc_phase(crc1), .done(done1)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    crc;
    } vec_t;

    vec_t        vecs[4];
    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] bits;
    logic        hv[HN];
    logic        hd[HN];
    logic [DW-1:0] acc[$];

    // Remainder of an 18-bit polynomial modulo x^4+x+1 by schoolbook long division.
    function automatic logic [3:0] poly_mod18(input logic [17:0] m);
        logic [17:0] r;
        logic [17:0] g;
        r = m;
        for (int i = 17; i >= 4; i--) begin
            if (r[i]) begin
                g = 18'(5'b10011);
                r = r ^ (g << (i - 4));
            end
        end
        return r[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [DW-1:0] d, output logic [17:0] fb);
        logic sv[NV+2], sd[NV+2], sc[NV+2], sdn[NV+2], sr[NV+2];
        int   ncrc_in, ncrc, ndone, nready, nvalid, unstable;
        bit   ok;
        fb = '0;
        wait_ready(ok);
        if (!ok) begin
            check("ready_wait", 0, 1);
            return;
        end
        start   = 1'b1;
        data_in = d;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NV + 2; i++) begin
            data_in = DW'($urandom);
            sv[i]  = dout_valid;
            sd[i]  = dout;
            sc[i]  = crc_phase;
            sdn[i] = done;
            sr[i]  = ready;
            if (i < NV + 1) @(negedge clk);
        end
        ncrc_in = 0; ncrc = 0; ndone = 0; nready = 0; nvalid = 0; unstable = 0;
        for (int i = 0; i < NV + 2; i++) begin
            nvalid += int'(sv[i]);
            ncrc   += int'(sc[i]);
            ndone  += int'(sdn[i]);
            nready += int'(sr[i]);
            if (i >= NV - 4 * BD && i < NV) ncrc_in += int'(sc[i]);
            if (i < NV) begin
                if (i % BD == 0) fb[FL-1-(i/BD)] = sd[i];
                if (sd[i] !== sd[i - (i % BD)]) unstable++;
            end
        end
        check("valid_len", nvalid, NV);
        check("valid_tail", {sv[NV], sv[NV+1]}, 0);
        check("crc_phase", ncrc_in * 256 + ncrc, 16 * BD * 256 / 4 * 1 + 16 * BD / 4 * 1);
        check("done_pulse", int'(sdn[NV]) * 256 + ndone, 257);
        check("ready_return", int'(sr[NV+1]) * 256 + nready, 257);
        check("dout_stable", unstable, 0);
        check("stream", fb, {d, poly_mod18({d, 4'b0000})});
        check("rx_remainder", poly_mod18(fb), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic [17:0]   b1;
        int            nruns, prev_end, len, s, ndone, nvalid, nv1;
        logic          s1d[19], s1v[19], s1dn[19];
        bit            ok;

        rst = 1'b0; start = 1'b0; data_in = '0; start1 = 1'b0; data1 = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {ready, dout, dout_valid, crc_phase, done}, 5'b10000);
        rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{data: 14'h0000, crc: 4'b0000};
        vecs[1] = '{data: 14'h0001, crc: 4'b0011};
        vecs[2] = '{data: 14'h2000, crc: 4'b0100};
        vecs[3] = '{data: 14'h0002, crc: 4'b0110};
        for (int k = 0; k < 4; k++) begin
            run_frame(vecs[k].data, bits);
            check("table_crc", bits[3:0], vecs[k].crc);
            check("table_data", bits[17:4], vecs[k].data);
        end

        // Each run_frame ends with ready high, so these go out at minimum spacing.
        for (int k = 0; k < 200; k++) begin
            d = DW'($urandom);
            run_frame(d, bits);
        end

        // start held high with data_in churning every clock.
        start = 1'b1;
        for (int i = 0; i < HN; i++) begin
            if (i == 222) start = 1'b0;
            data_in = DW'($urandom);
            if (start && ready) acc.push_back(data_in);
            hv[i] = dout_valid;
            hd[i] = dout;
            @(negedge clk);
        end
        nruns = 0; prev_end = 0;
        for (int i = 1; i < HN; i++) begin
            if (hv[i] && !hv[i-1]) begin
                s = i;
                len = 0;
                while (s + len < HN && hv[s+len]) len++;
                b1 = '0;
                for (int b = 0; b < FL; b++) begin
                    if (s + b * BD < HN) b1[FL-1-b] = hd[s + b * BD];
                end
                if (nruns > 0) check("hold_gap", s - prev_end - 1, 2);
                check("hold_len", len, NV);
                if (nruns < acc.size()) begin
                    check("hold_stream", b1, {acc[nruns], poly_mod18({acc[nruns], 4'b0000})});
                end else begin
                    check("hold_extra_frame", nruns, acc.size());
                end
                prev_end = s + len - 1;
                nruns++;
            end
        end
        check("hold_frames", nruns, 3);
        check("hold_accepts", acc.size(), 3);

        // Reset 30 clocks into a frame must clear outputs before the next edge.
        wait_ready(ok);
        check("rst_pre_ready", ok, 1);
        start   = 1'b1;
        data_in = DW'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("rst_pre_valid", dout_valid, 1);
        #2 rst = 1'b0;
        #1 check("rst_async_outs", {ready, dout, dout_valid, crc_phase, done}, 5'b10000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", ready, 1);
        ndone = 0; nvalid = 0;
        for (int i = 0; i < 80; i++) begin
            ndone  += int'(done);
            nvalid += int'(dout_valid);
            @(negedge clk);
        end
        check("rst_no_done", ndone, 0);
        check("rst_no_valid", nvalid, 0);
        d = DW'($urandom);
        run_frame(d, bits);

        // BIT_DIV=1 build: one bit per clock.
        check("bd1_ready", ready1, 1);
        start1 = 1'b1;
        data1  = 14'h0001;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 19; i++) begin
            data1  = DW'($urandom);
            s1d[i]  = dout1;
            s1v[i]  = dv1;
            s1dn[i] = done1;
            if (i < 18) @(negedge clk);
        end
        b1 = '0; nv1 = 0;
        for (int i = 0; i < 19; i++) begin
            nv1 += int'(s1v[i]);
            if (i < 18) b1[17-i] = s1d[i];
        end
        check("bd1_stream", b1, {14'h0001, 4'b0011});
        check("bd1_valid", nv1, 18);
        check("bd1_done", s1dn[18], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
